// File: rtl/trig_link_framer.sv
// Trigger-link framer: packs per-BX S-bit cluster payloads into 16-bit
// 8b/10b words for the optical trigger MGTs. An idle alignment sequence
// follows link-ready, TTC pulses are latched sticky, and an optional CRC-8
// trailer closes each frame.
module trig_link_framer #(
    parameter int NUM_LINKS       = 2,
    parameter int FRAME_WORDS     = 4,
    parameter int ENABLE_CRC      = 0,
    parameter int SYNC_FRAMES     = 16,
    parameter int ALLOW_TTC_CHARS = 1,
    parameter int FRAME_CTRL_TTC  = 1,
    localparam int PAYLOAD_BITS   = 16*FRAME_WORDS - 8 - 8*ENABLE_CRC
) (
    input  logic                              clk_160,
    input  logic                              reset,
    input  logic                              ready,
    input  logic [NUM_LINKS*PAYLOAD_BITS-1:0] gem_data,
    input  logic [NUM_LINKS-1:0]              overflow_i,
    input  logic                              bc0_i,
    input  logic                              resync_i,
    input  logic [1:0]                        bxn_counter_lsbs,
    output logic [NUM_LINKS*16-1:0]           tx_data,
    output logic [NUM_LINKS*2-1:0]            tx_isk,
    output logic                              frame_start,
    output logic                              link_up
);

    localparam int PW = $clog2(FRAME_WORDS);
    localparam int SW = (SYNC_FRAMES > 1) ? $clog2(SYNC_FRAMES) : 1;
    // Per-link payload width without the CRC byte; the zero-padded lane keeps
    // every word select in range whether or not the trailer is enabled.
    localparam int HW = 16*FRAME_WORDS - 8;
    localparam logic [PW-1:0] LAST_PHASE = PW'(FRAME_WORDS - 1);
    localparam logic [SW-1:0] LAST_SYNC  = SW'((SYNC_FRAMES > 0) ? SYNC_FRAMES - 1 : 0);

    typedef enum logic [1:0] {ST_RST, ST_SYNC, ST_RUN} state_t;

    state_t                            state, state_next, cur_mode;
    logic [PW-1:0]                     phase, phase_next, cur_phase;
    logic [1:0]                        frame_cnt, frame_next;
    logic [SW-1:0]                     sync_cnt, sync_next;
    logic                              bc0_q, bc0_next, resync_q, resync_next;
    logic [NUM_LINKS-1:0]              ovf_q, ovf_next;
    logic [NUM_LINKS*PAYLOAD_BITS-1:0] hold, hold_next;
    logic [NUM_LINKS*16-1:0]           data_next;
    logic [NUM_LINKS*2-1:0]            isk_next;
    logic                              fs_next, lu_next;

    logic                              drop, wrap;
    logic                              bc0_pend, resync_pend;
    logic [NUM_LINKS-1:0]              ovf_pend;
    logic [1:0]                        seq_idx;
    logic [7:0]                        seq_k, sep;
    logic [HW-1:0]                     lane;
    logic [15:0]                       word;

    // CRC-8 (poly 0x07, init 0, no reflection), payload MSB first.
    function automatic logic [7:0] crc8(input logic [PAYLOAD_BITS-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < PAYLOAD_BITS; i++) begin
            fb = c[7] ^ d[PAYLOAD_BITS-1-i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Next-state, sticky-flag and output-word selection.
    always_comb begin
        drop      = reset | ~ready;
        cur_mode  = state;
        cur_phase = phase;
        // Leaving RST is folded into the same edge so the first word of the
        // new mode leaves one cycle after ready rises.
        if (state == ST_RST) begin
            if (SYNC_FRAMES == 0) cur_mode = ST_RUN;
            else                  cur_mode = ST_SYNC;
            cur_phase = '0;
        end
        wrap = (cur_phase == LAST_PHASE);

        bc0_pend    = bc0_q | bc0_i;
        resync_pend = resync_q | resync_i;
        ovf_pend    = ovf_q | overflow_i;

        seq_idx = (FRAME_CTRL_TTC != 0) ? bxn_counter_lsbs : frame_cnt;
        case (seq_idx)
            2'd0:    seq_k = 8'hBC;
            2'd1:    seq_k = 8'hF7;
            2'd2:    seq_k = 8'hFB;
            default: seq_k = 8'hFD;
        endcase

        state_next = cur_mode;
        phase_next = wrap ? '0 : cur_phase + 1'b1;
        frame_next = wrap ? frame_cnt + 2'd1 : frame_cnt;
        sync_next  = sync_cnt;
        hold_next  = (cur_phase == '0) ? gem_data : hold;
        fs_next    = (cur_phase == '0);
        lu_next    = (cur_mode == ST_RUN);

        if (cur_phase == '0) begin
            bc0_next    = 1'b0;
            resync_next = 1'b0;
            ovf_next    = '0;
        end else begin
            bc0_next    = bc0_pend;
            resync_next = resync_pend;
            ovf_next    = ovf_pend;
        end

        if (cur_mode == ST_SYNC && wrap) begin
            if (sync_cnt == LAST_SYNC) begin
                state_next = ST_RUN;
                sync_next  = '0;
            end else begin
                sync_next = sync_cnt + 1'b1;
            end
        end

        data_next = '0;
        isk_next  = '0;
        sep       = '0;
        lane      = '0;
        word      = '0;
        for (int unsigned n = 0; n < NUM_LINKS; n++) begin
            sep = seq_k;
            if (ALLOW_TTC_CHARS != 0) begin
                if (bc0_pend)         sep = 8'h1C;
                else if (resync_pend) sep = 8'h3C;
                else if (ovf_pend[n]) sep = 8'hFC;
            end
            lane = '0;
            lane[PAYLOAD_BITS-1:0] = hold[n*PAYLOAD_BITS +: PAYLOAD_BITS];
            word = '0;
            for (int unsigned k = 1; k < FRAME_WORDS; k++) begin
                if (cur_phase == PW'(k)) word = lane[16*k-8 +: 16];
            end
            if (ENABLE_CRC != 0 && cur_phase == LAST_PHASE)
                word[15:8] = crc8(hold[n*PAYLOAD_BITS +: PAYLOAD_BITS]);

            if (cur_mode == ST_SYNC) begin
                data_next[n*16 +: 16] = 16'h50BC;
                isk_next[n*2 +: 2]    = 2'b01;
            end else if (cur_phase == '0) begin
                data_next[n*16 +: 16] = {gem_data[n*PAYLOAD_BITS +: 8], sep};
                isk_next[n*2 +: 2]    = 2'b01;
            end else begin
                data_next[n*16 +: 16] = word;
                isk_next[n*2 +: 2]    = 2'b00;
            end
        end

        if (drop) begin
            state_next  = ST_RST;
            phase_next  = '0;
            frame_next  = '0;
            sync_next   = '0;
            bc0_next    = 1'b0;
            resync_next = 1'b0;
            ovf_next    = '0;
            fs_next     = 1'b0;
            lu_next     = 1'b0;
            data_next   = {NUM_LINKS{16'hFFFC}};
            isk_next    = {NUM_LINKS{2'b01}};
        end
    end

    // Control state and registered link outputs.
    always_ff @(posedge clk_160) begin
        if (reset) begin
            state       <= ST_RST;
            phase       <= '0;
            frame_cnt   <= '0;
            sync_cnt    <= '0;
            bc0_q       <= 1'b0;
            resync_q    <= 1'b0;
            ovf_q       <= '0;
            tx_data     <= {NUM_LINKS{16'hFFFC}};
            tx_isk      <= {NUM_LINKS{2'b01}};
            frame_start <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            state       <= state_next;
            phase       <= phase_next;
            frame_cnt   <= frame_next;
            sync_cnt    <= sync_next;
            bc0_q       <= bc0_next;
            resync_q    <= resync_next;
            ovf_q       <= ovf_next;
            tx_data     <= data_next;
            tx_isk      <= isk_next;
            frame_start <= fs_next;
            link_up     <= lu_next;
        end
    end

    // Payload holding register, loaded at phase 0 so a frame is never torn.
    always_ff @(posedge clk_160) begin
        hold <= hold_next;
    end

endmodule
